// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS main control unit:
// FSM state encoding, opcode values, datapath select encodings and the
// control word passed from the output decoder to the top.
package mc_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_WB_R      = 4'd3,
    S_EXEC_ADDI = 4'd4,
    S_EXEC_ORI  = 4'd5,
    S_WB_I      = 4'd6,
    S_MEM_ADDR  = 4'd7,
    S_MEM_RD    = 4'd8,
    S_WB_MEM    = 4'd9,
    S_MEM_WR    = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_JAL       = 4'd13
  } state_e;

  // Supported opcodes (IR[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

  // pc_src: PC input mux
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // reg_dst: destination register index mux
  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  // Link register selected by REG_DST_RA (lives in the datapath)
  localparam logic [4:0] RA_REG = 5'd31;

  // mem_to_reg: register write-data mux
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // alu_srcb: ALU operand B mux
  localparam logic [2:0] SRCB_B        = 3'b000;
  localparam logic [2:0] PC_INC_SEL    = 3'b001;
  localparam logic [2:0] SRCB_SEXT     = 3'b010;
  localparam logic [2:0] SRCB_SEXT_SH2 = 3'b011;
  localparam logic [2:0] SRCB_ZEXT     = 3'b100;

  // alu_op: ALU operation class
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_OR    = 2'b11;

  // State-decoded control word (everything except the opcode-dependent illegal flag)
  typedef struct packed {
    logic       ir_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       iord;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_srca;
    logic [2:0] alu_srcb;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_en;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Control-unit <-> datapath bundle.
// master: control unit (receives opcode/funct/zero, drives selects/enables).
// slave : datapath (drives opcode/funct/zero, receives selects/enables).
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       ir_wr;
  logic       mem_rd;
  logic       mem_wr;
  logic       iord;
  logic       reg_wr;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       alu_srca;
  logic [2:0] alu_srcb;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       illegal;

  modport master (
    input  opcode, funct, zero,
    output ir_wr, mem_rd, mem_wr, iord, reg_wr, reg_dst, mem_to_reg,
           alu_srca, alu_srcb, alu_op, pc_src, pc_en, illegal
  );

  modport slave (
    output opcode, funct, zero,
    input  ir_wr, mem_rd, mem_wr, iord, reg_wr, reg_dst, mem_to_reg,
           alu_srca, alu_srcb, alu_op, pc_src, pc_en, illegal
  );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control word decoder.
// Ports: state (current FSM state), zero (ALU zero flag, gates pc_en in BRANCH),
//        ctrl (decoded datapath control word).
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   zero,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_rd   = 1'b1;
        ctrl.ir_wr    = 1'b1;
        ctrl.alu_srcb = PC_INC_SEL;
        ctrl.alu_op   = ALU_OP_ADD;
        ctrl.pc_src   = PC_SRC_ALU;
        ctrl.pc_en    = 1'b1;
      end
      // Speculatively compute the branch target into ALUOut
      S_DECODE: begin
        ctrl.alu_srcb = SRCB_SEXT_SH2;
        ctrl.alu_op   = ALU_OP_ADD;
      end
      S_EXEC_R: begin
        ctrl.alu_srca = 1'b1;
        ctrl.alu_srcb = SRCB_B;
        ctrl.alu_op   = ALU_OP_FUNCT;
      end
      S_WB_R: begin
        ctrl.reg_wr     = 1'b1;
        ctrl.reg_dst    = REG_DST_RD;
        ctrl.mem_to_reg = M2R_ALUOUT;
      end
      S_EXEC_ADDI, S_MEM_ADDR: begin
        ctrl.alu_srca = 1'b1;
        ctrl.alu_srcb = SRCB_SEXT;
        ctrl.alu_op   = ALU_OP_ADD;
      end
      S_EXEC_ORI: begin
        ctrl.alu_srca = 1'b1;
        ctrl.alu_srcb = SRCB_ZEXT;
        ctrl.alu_op   = ALU_OP_OR;
      end
      S_WB_I: begin
        ctrl.reg_wr     = 1'b1;
        ctrl.reg_dst    = REG_DST_RT;
        ctrl.mem_to_reg = M2R_ALUOUT;
      end
      S_MEM_RD: begin
        ctrl.mem_rd = 1'b1;
        ctrl.iord   = 1'b1;
      end
      S_WB_MEM: begin
        ctrl.reg_wr     = 1'b1;
        ctrl.reg_dst    = REG_DST_RT;
        ctrl.mem_to_reg = M2R_MDR;
      end
      S_MEM_WR: begin
        ctrl.mem_wr = 1'b1;
        ctrl.iord   = 1'b1;
      end
      // Only output that looks at a live input: branch taken iff A == B
      S_BRANCH: begin
        ctrl.alu_srca = 1'b1;
        ctrl.alu_srcb = SRCB_B;
        ctrl.alu_op   = ALU_OP_SUB;
        ctrl.pc_src   = PC_SRC_ALUOUT;
        ctrl.pc_en    = zero;
      end
      S_JUMP: begin
        ctrl.pc_src = PC_SRC_JUMP;
        ctrl.pc_en  = 1'b1;
      end
      // Register file captures PC (already PC+4) before the PC is overwritten
      S_JAL: begin
        ctrl.pc_src     = PC_SRC_JUMP;
        ctrl.pc_en      = 1'b1;
        ctrl.reg_wr     = 1'b1;
        ctrl.reg_dst    = REG_DST_RA;
        ctrl.mem_to_reg = M2R_PC;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main control unit: sequences FETCH/DECODE/execute states
// and drives datapath mux selects, write enables and the PC load enable.
// Ports: clk, rst_n (synchronous, active low), bus (mc_ctrl_if.master:
//        opcode/funct/zero in, control word + illegal out).
// Optional MC_CTRL_PERF_EN: adds instr_cnt[31:0] and cycle_cnt[31:0]
//        performance counters.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  mc_ctrl_if.master    bus
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0]  instr_cnt,
  output logic [31:0]  cycle_cnt
`endif
);

  state_e state_q, state_d;
  logic   illegal_op;
  ctrl_t  ctrl, ctrl_g;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; opcode is only consulted in DECODE and MEM_ADDR
  always_comb begin
    state_d    = S_FETCH;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_EXEC_ADDI;
          OP_ORI:       state_d = S_EXEC_ORI;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_EXEC_R:    state_d = S_WB_R;
      S_EXEC_ADDI: state_d = S_WB_I;
      S_EXEC_ORI:  state_d = S_WB_I;
      S_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:    state_d = S_WB_MEM;
      default:     state_d = S_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state (state_q),
    .zero  (bus.zero),
    .ctrl  (ctrl)
  );

  // Reset quiets every strobe so an abandoned instruction cannot write
  always_comb begin
    ctrl_g = rst_n ? ctrl : '0;
  end

  assign bus.ir_wr      = ctrl_g.ir_wr;
  assign bus.mem_rd     = ctrl_g.mem_rd;
  assign bus.mem_wr     = ctrl_g.mem_wr;
  assign bus.iord       = ctrl_g.iord;
  assign bus.reg_wr     = ctrl_g.reg_wr;
  assign bus.reg_dst    = ctrl_g.reg_dst;
  assign bus.mem_to_reg = ctrl_g.mem_to_reg;
  assign bus.alu_srca   = ctrl_g.alu_srca;
  assign bus.alu_srcb   = ctrl_g.alu_srcb;
  assign bus.alu_op     = ctrl_g.alu_op;
  assign bus.pc_src     = ctrl_g.pc_src;
  assign bus.pc_en      = ctrl_g.pc_en;
  assign bus.illegal    = rst_n & illegal_op;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  // FETCH never loops on itself, so next==FETCH marks an instruction retiring
  always_comb begin
    cycle_cnt_d = cycle_cnt_q + 32'd1;
    instr_cnt_d = instr_cnt_q;
    if (state_d == S_FETCH) instr_cnt_d = instr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign instr_cnt = instr_cnt_q;
  assign cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: the stimulus process expands each
// instruction into its expected per-cycle control words and queues them;
// a monitor on the falling edge pops and compares one word per cycle.
module tb_mc_ctrl_fsm;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mc_ctrl_if bus ();

`ifdef MC_CTRL_PERF_EN
  logic [31:0] instr_cnt, cycle_cnt;
`endif

  mc_ctrl_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MC_CTRL_PERF_EN
    ,
    .instr_cnt (instr_cnt),
    .cycle_cnt (cycle_cnt)
`endif
  );

  typedef struct {
    logic [18:0] w;
    logic [31:0] ic;
    logic [31:0] cc;
  } exp_t;

  exp_t        exp_q[$];
  logic [18:0] seq_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] m_ic = '0;
  logic [31:0] m_cc = '0;

  // {ir_wr, mem_rd, mem_wr, iord, reg_wr, reg_dst, mem_to_reg, alu_srca, alu_srcb, alu_op, pc_src, pc_en, illegal}
  function automatic logic [18:0] cw(input bit ir, input bit mr, input bit mw, input bit io,
                                     input bit rw, input logic [1:0] rd, input logic [1:0] m2r,
                                     input bit sa, input logic [2:0] sb, input logic [1:0] aop,
                                     input logic [1:0] ps, input bit pe, input bit il);
    return {ir, mr, mw, io, rw, rd, m2r, sa, sb, aop, ps, pe, il};
  endfunction

  // Instruction -> microsequence of control words, FETCH first
  task automatic build_seq(input logic [5:0] op, input bit z);
    logic [18:0] dec;
    dec = cw(0,0,0,0,0,2'b00,2'b00,0,3'b011,2'b00,2'b00,0,0);
    seq_q.delete();
    seq_q.push_back(cw(1,1,0,0,0,2'b00,2'b00,0,3'b001,2'b00,2'b00,1,0));
    case (op)
      6'b000000: begin
        seq_q.push_back(dec);
        seq_q.push_back(cw(0,0,0,0,0,2'b00,2'b00,1,3'b000,2'b10,2'b00,0,0));
        seq_q.push_back(cw(0,0,0,0,1,2'b01,2'b00,0,3'b000,2'b00,2'b00,0,0));
      end
      6'b100011: begin
        seq_q.push_back(dec);
        seq_q.push_back(cw(0,0,0,0,0,2'b00,2'b00,1,3'b010,2'b00,2'b00,0,0));
        seq_q.push_back(cw(0,1,0,1,0,2'b00,2'b00,0,3'b000,2'b00,2'b00,0,0));
        seq_q.push_back(cw(0,0,0,0,1,2'b00,2'b01,0,3'b000,2'b00,2'b00,0,0));
      end
      6'b101011: begin
        seq_q.push_back(dec);
        seq_q.push_back(cw(0,0,0,0,0,2'b00,2'b00,1,3'b010,2'b00,2'b00,0,0));
        seq_q.push_back(cw(0,0,1,1,0,2'b00,2'b00,0,3'b000,2'b00,2'b00,0,0));
      end
      6'b000100: begin
        seq_q.push_back(dec);
        seq_q.push_back(cw(0,0,0,0,0,2'b00,2'b00,1,3'b000,2'b01,2'b01,z,0));
      end
      6'b001000: begin
        seq_q.push_back(dec);
        seq_q.push_back(cw(0,0,0,0,0,2'b00,2'b00,1,3'b010,2'b00,2'b00,0,0));
        seq_q.push_back(cw(0,0,0,0,1,2'b00,2'b00,0,3'b000,2'b00,2'b00,0,0));
      end
      6'b001101: begin
        seq_q.push_back(dec);
        seq_q.push_back(cw(0,0,0,0,0,2'b00,2'b00,1,3'b100,2'b11,2'b00,0,0));
        seq_q.push_back(cw(0,0,0,0,1,2'b00,2'b00,0,3'b000,2'b00,2'b00,0,0));
      end
      6'b000010: begin
        seq_q.push_back(dec);
        seq_q.push_back(cw(0,0,0,0,0,2'b00,2'b00,0,3'b000,2'b00,2'b10,1,0));
      end
      6'b000011: begin
        seq_q.push_back(dec);
        seq_q.push_back(cw(0,0,0,0,1,2'b10,2'b10,0,3'b000,2'b00,2'b10,1,0));
      end
      default: seq_q.push_back(cw(0,0,0,0,0,2'b00,2'b00,0,3'b011,2'b00,2'b00,0,1));
    endcase
  endtask

  task automatic push_exp(input logic [18:0] w);
    exp_t e;
    e.w  = w;
    e.ic = m_ic;
    e.cc = m_cc;
    exp_q.push_back(e);
  endtask

  task automatic reset_cycle();
    @(posedge clk); #1;
    rst_n      = 1'b0;
    bus.opcode = 6'($urandom);
    bus.funct  = 6'($urandom);
    bus.zero   = 1'($urandom);
    push_exp(19'd0);
    m_ic = '0;
    m_cc = '0;
  endtask

  // Runs one instruction; rst_at >= 0 pulls reset in that cycle and abandons it
  task automatic run_instr(input logic [5:0] op, input bit z, input int rst_at);
    bit mem;
    int n;
    build_seq(op, z);
    n   = seq_q.size();
    mem = (op == 6'b100011) || (op == 6'b101011);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.funct  = 6'($urandom);
      bus.zero   = 1'($urandom);
      bus.opcode = 6'($urandom);
      if (i == 1 || (i == 2 && mem)) bus.opcode = op;
      if (i == 2 && op == 6'b000100) bus.zero = z;
      if (i == rst_at) begin
        rst_n = 1'b0;
        push_exp(19'd0);
        m_ic = '0;
        m_cc = '0;
        return;
      end
      rst_n = 1'b1;
      push_exp(seq_q[i]);
      m_cc = m_cc + 32'd1;
      if (i == n - 1) m_ic = m_ic + 32'd1;
    end
  endtask

  // Monitor: one expected word per cycle, sampled mid-cycle
  initial begin
    exp_t        e;
    logic [18:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {bus.ir_wr, bus.mem_rd, bus.mem_wr, bus.iord, bus.reg_wr, bus.reg_dst,
               bus.mem_to_reg, bus.alu_srca, bus.alu_srcb, bus.alu_op, bus.pc_src,
               bus.pc_en, bus.illegal};
        vectors++;
        if (got !== e.w) begin
          miscompares++;
          $display("FAIL ctrl_word t=%0t got=%b exp=%b", $time, got, e.w);
        end
`ifdef MC_CTRL_PERF_EN
        vectors++;
        if (instr_cnt !== e.ic) begin
          miscompares++;
          $display("FAIL instr_cnt t=%0t got=%0d exp=%0d", $time, instr_cnt, e.ic);
        end
        vectors++;
        if (cycle_cnt !== e.cc) begin
          miscompares++;
          $display("FAIL cycle_cnt t=%0t got=%0d exp=%0d", $time, cycle_cnt, e.cc);
        end
`endif
      end
    end
  end

  logic [5:0] ops [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b001000, 6'b001101, 6'b000010, 6'b000011};

  initial begin
    int k;
    int ra;
    logic [5:0] op;
    rst_n      = 1'b0;
    bus.opcode = '0;
    bus.funct  = '0;
    bus.zero   = 1'b0;
    repeat (3) reset_cycle();

    // Directed: lw, beq taken/not taken, jal, illegal
    run_instr(6'b100011, 1'b0, -1);
    run_instr(6'b000100, 1'b1, -1);
    run_instr(6'b000100, 1'b0, -1);
    run_instr(6'b000011, 1'b0, -1);
    run_instr(6'b111111, 1'b0, -1);

    // Fresh reset, then add followed by sw (counters checked at next FETCH)
    reset_cycle();
    run_instr(6'b000000, 1'b0, -1);
    run_instr(6'b101011, 1'b0, -1);

    // lw abandoned by reset in its MEM_RD cycle
    run_instr(6'b100011, 1'b0, 3);
    run_instr(6'b001000, 1'b0, -1);
    run_instr(6'b001101, 1'b0, -1);
    run_instr(6'b000010, 1'b0, -1);

    // Random instruction stream with occasional reset injection
    for (int n = 0; n < 80; n++) begin
      k  = $urandom_range(0, 9);
      op = (k < 8) ? ops[k] : 6'($urandom);
      ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(op, 1'($urandom), ra);
    end

    // Trailing FETCH so the last counter increments are observed
    run_instr(6'b000010, 1'b0, 1);

    // Bounded drain of the scoreboard
    for (int t = 0; t < 5 && exp_q.size() != 0; t++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    if (vectors < 12) begin
      miscompares++;
      $display("FAIL vector_count got=%0d exp>=12", vectors);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
